// File: rtl/fifo_wr_skid.sv
// fifo_wr_skid: 2-entry write-side skid buffer feeding winc/wdata of an async FIFO.
// Optional pop counter output wcnt enabled by defining WR_SKID_CNT_EN.
module fifo_wr_skid #(
  parameter int DSIZE = 8
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic             wflush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DSIZE-1:0] s_data,
  output logic             winc,
  output logic [DSIZE-1:0] wdata,
  input  logic             wfull
`ifdef WR_SKID_CNT_EN
  ,
  output logic [15:0]      wcnt
`endif
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t cnt_q, cnt_d;
  logic [DSIZE-1:0] head_q, head_d, tail_q, tail_d;
  logic s_ready_q, s_ready_d;
  logic push, pop;
  // wfull is used only here, unregistered, so the write decision is its value at the edge
  assign push    = s_valid & s_ready_q & ~wflush;
  assign pop     = winc & ~wfull;
  assign winc    = cnt_q != EMPTY;
  assign wdata   = head_q;
  assign s_ready = s_ready_q;
  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    unique case (cnt_q)
      EMPTY: begin
        cnt_d  = push ? ONE : EMPTY;
        head_d = push ? s_data : head_q;
      end
      ONE: begin
        cnt_d  = (push & ~pop) ? TWO : (~push & pop) ? EMPTY : ONE;
        head_d = (push & pop) ? s_data : head_q;
        tail_d = (push & ~pop) ? s_data : tail_q;
      end
      TWO: begin
        cnt_d  = pop ? ONE : TWO;
        head_d = pop ? tail_q : head_q;
      end
      default: cnt_d = EMPTY;
    endcase
    if (wflush) cnt_d = EMPTY;
    s_ready_d = cnt_d != TWO;
  end
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      cnt_q     <= EMPTY;
      head_q    <= '0;
      tail_q    <= '0;
      s_ready_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      s_ready_q <= s_ready_d;
    end
  end
`ifdef WR_SKID_CNT_EN
  logic [15:0] wcnt_q, wcnt_d;
  assign wcnt   = wcnt_q;
  assign wcnt_d = (pop && wcnt_q != 16'hFFFF) ? wcnt_q + 16'd1 : wcnt_q;
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) wcnt_q <= '0;
    else wcnt_q <= wcnt_d;
  end
`endif
endmodule

// File: tb/tb_fifo_wr_skid.sv
// tb_fifo_wr_skid: directed bench with a queue model of the skid buffer and its write stream.
module tb_fifo_wr_skid;
  logic wclk = 1'b0;
  logic wrst, wflush, s_valid, wfull, s_ready, winc;
  logic [7:0] s_data, wdata;
`ifdef WR_SKID_CNT_EN
  logic [15:0] wcnt;
`endif
  int total = 0, bad = 0;
  logic [7:0] mq[$], mlog[$], dlog[$], exp_w[$];
  logic mrdy;
  int unsigned mcnt;

  always #5 wclk = ~wclk;

  fifo_wr_skid #(.DSIZE(8)) dut (
    .wclk(wclk), .wrst(wrst), .wflush(wflush), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .winc(winc), .wdata(wdata), .wfull(wfull)
`ifdef WR_SKID_CNT_EN
    , .wcnt(wcnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #2;
  endtask

  // Model: buffer is a queue of at most two words; a write takes the oldest word.
  always @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      mq.delete();
      mrdy = 1'b0;
      mcnt = 0;
    end else begin
      logic mpush;
      mpush = s_valid && mrdy && !wflush;
      if (mq.size() > 0 && !wfull) begin
        mlog.push_back(mq.pop_front());
        if (mcnt < 65535) mcnt++;
      end
      if (wflush) mq.delete();
      else if (mpush) mq.push_back(s_data);
      mrdy = mq.size() < 2;
    end
  end

  always @(posedge wclk)
    if (!wrst && winc && !wfull) dlog.push_back(wdata);

  always @(negedge wclk) begin
    check("s_ready", {31'd0, s_ready}, {31'd0, mrdy});
    check("winc", {31'd0, winc}, {31'd0, mq.size() != 0});
    if (mq.size() != 0) check("wdata", {24'd0, wdata}, {24'd0, mq[0]});
`ifdef WR_SKID_CNT_EN
    check("wcnt", {16'd0, wcnt}, mcnt);
`endif
  end

  initial begin
    wrst = 1'b1; wflush = 1'b0; s_valid = 1'b0; wfull = 1'b0; s_data = 8'h00;
    #7;
    check("rst_s_ready", {31'd0, s_ready}, 0);
    check("rst_winc", {31'd0, winc}, 0);
    check("rst_wdata", {24'd0, wdata}, 0);
    wrst = 1'b0;
    tick();
    check("ready_after_rst", {31'd0, s_ready}, 1);
    // stream 0x01..0x10
    s_valid = 1'b1; s_data = 8'h01;
    tick();
    check("first_wdata", {24'd0, wdata}, 32'h01);
    check("first_winc", {31'd0, winc}, 1);
    for (int i = 2; i <= 16; i++) begin
      s_data = 8'(i);
      tick();
    end
    s_valid = 1'b0;
    repeat (3) tick();
    // stall with wfull high
    wfull = 1'b1; s_valid = 1'b1; s_data = 8'hA0;
    tick();
    s_data = 8'hA1;
    tick();
    s_data = 8'hA2;
    repeat (3) tick();
    check("stall_s_ready", {31'd0, s_ready}, 0);
    check("stall_winc", {31'd0, winc}, 1);
    check("stall_wdata", {24'd0, wdata}, 32'hA0);
    wfull = 1'b0;
    tick();
    tick();
    s_valid = 1'b0;
    repeat (3) tick();
    // sub-cycle wfull pulse not spanning an edge
    s_valid = 1'b1; s_data = 8'h55;
    tick();
    s_valid = 1'b0;
    check("pulse_wdata", {24'd0, wdata}, 32'h55);
    #2 wfull = 1'b1;
    #2 wfull = 1'b0;
    tick();
    check("pulse_drained", {31'd0, winc}, 0);
    // flush with two entries held
    wfull = 1'b1; s_valid = 1'b1; s_data = 8'h11;
    tick();
    s_data = 8'h22;
    tick();
    s_data = 8'h33; wflush = 1'b1;
    tick();
    check("flush_winc", {31'd0, winc}, 0);
    check("flush_s_ready", {31'd0, s_ready}, 1);
    wflush = 1'b0; s_valid = 1'b0; wfull = 1'b0;
    tick();
    check("flush_idle", {31'd0, winc}, 0);
    // flush coincident with a pop still writes the head
    s_valid = 1'b1; s_data = 8'h66;
    tick();
    s_valid = 1'b0; wflush = 1'b1;
    tick();
    wflush = 1'b0;
    check("flushpop_winc", {31'd0, winc}, 0);
    // async reset mid-cycle with two entries
    wfull = 1'b1; s_valid = 1'b1; s_data = 8'h77;
    tick();
    s_data = 8'h88;
    tick();
    s_valid = 1'b0;
    #1 wrst = 1'b1;
    #1;
    check("arst_winc", {31'd0, winc}, 0);
    check("arst_s_ready", {31'd0, s_ready}, 0);
    check("arst_wdata", {24'd0, wdata}, 0);
    @(negedge wclk);
    #1 wrst = 1'b0; wfull = 1'b0;
    tick();
    check("arst_ready_after", {31'd0, s_ready}, 1);
    // written stream must match the hand list exactly
    for (int i = 1; i <= 16; i++) exp_w.push_back(8'(i));
    exp_w.push_back(8'hA0); exp_w.push_back(8'hA1); exp_w.push_back(8'hA2);
    exp_w.push_back(8'h55); exp_w.push_back(8'h66);
    check("mlog_size", mlog.size(), exp_w.size());
    check("dlog_size", dlog.size(), exp_w.size());
    for (int i = 0; i < exp_w.size(); i++) begin
      if (i < mlog.size()) check("mlog_word", {24'd0, mlog[i]}, {24'd0, exp_w[i]});
      if (i < dlog.size()) check("dlog_word", {24'd0, dlog[i]}, {24'd0, exp_w[i]});
    end
`ifdef WR_SKID_CNT_EN
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_data = 8'(i);
      tick();
    end
    s_valid = 1'b0;
    repeat (2) tick();
    check("wcnt_5", {16'd0, wcnt}, 5);
    s_valid = 1'b1;
    for (int i = 0; i < 65528; i++) begin
      s_data = 8'(i);
      tick();
    end
    s_valid = 1'b0;
    repeat (2) tick();
    check("wcnt_near_sat", {16'd0, wcnt}, 32'hFFFD);
    s_valid = 1'b1;
    repeat (5) tick();
    s_valid = 1'b0;
    repeat (2) tick();
    check("wcnt_sat", {16'd0, wcnt}, 32'hFFFF);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
